// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU MEM stage (priority) vs DMA engine.
// Ports: clk_i/rst_i; cpu_* request/stall/read return; dma_* request/grant/read return;
//   mem_* single-port memory interface with one-cycle read latency.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_re_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_stall_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rvalid_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic              dma_lock_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_rvalid_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  // A grant seeing this count is the BURST_MAX-th grant of the lock.
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  typedef enum logic {
    CPU_PRI,
    DMA_BURST
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } own_e;

  state_e          state_q, state_d;
  own_e            own_q, own_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [BW-1:0]   burst_q, burst_d;

  logic cpu_act;
  logic dma_win;
  logic cpu_g;
  logic dma_g;

  assign cpu_act = cpu_re_i | cpu_we_i;

  always_comb begin
    dma_win = 1'b0;
    unique case (state_q)
      CPU_PRI:   dma_win = dma_req_i &
                           (~cpu_act | (starve_q == STARVE_TOP));
      DMA_BURST: dma_win = dma_req_i;
    endcase
  end

  assign dma_g = ~rst_i & dma_win;
  assign cpu_g = ~rst_i & cpu_act & ~dma_win;

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    starve_d = starve_q;
    own_d    = OWN_NONE;

    // Clearing on every DMA grant also covers the post-burst case:
    // the next conflict after a burst always goes to the CPU.
    if (dma_g | ~dma_req_i) begin
      starve_d = '0;
    end else if (cpu_g & (starve_q != STARVE_TOP)) begin
      starve_d = starve_q + 1'b1;
    end

    unique case (state_q)
      CPU_PRI: begin
        if (dma_g & dma_lock_i) begin
          state_d = DMA_BURST;
          burst_d = BW'(1);
        end
      end
      DMA_BURST: begin
        if (~dma_req_i) begin
          state_d = CPU_PRI;
        end else if (dma_g) begin
          burst_d = burst_q + 1'b1;
          if (~dma_lock_i | (burst_q == BURST_LAST)) begin
            state_d = CPU_PRI;
          end
        end
      end
    endcase

    if (cpu_g & cpu_re_i & ~cpu_we_i) begin
      own_d = OWN_CPU;
    end else if (dma_g & ~dma_we_i) begin
      own_d = OWN_DMA;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= CPU_PRI;
      own_q    <= OWN_NONE;
      starve_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      starve_q <= starve_d;
      burst_q  <= burst_d;
    end
  end

  assign cpu_stall_o = ~rst_i & cpu_act & ~cpu_g;
  assign dma_gnt_o   = dma_g;

  // A write wins over a read when the CPU sets both enables.
  assign mem_re_o = (cpu_g & cpu_re_i & ~cpu_we_i) |
                    (dma_g & ~dma_we_i);
  assign mem_we_o = (cpu_g & cpu_we_i) | (dma_g & dma_we_i);

  assign mem_addr_o  = rst_i ? '0 :
                       dma_g ? dma_addr_i : cpu_addr_i;
  assign mem_wdata_o = rst_i ? '0 :
                       dma_g ? dma_wdata_i : cpu_wdata_i;

  assign cpu_rdata_o  = rst_i ? '0 : mem_rdata_i;
  assign dma_rdata_o  = rst_i ? '0 : mem_rdata_i;
  assign cpu_rvalid_o = ~rst_i & (own_q == OWN_CPU);
  assign dma_rvalid_o = ~rst_i & (own_q == OWN_DMA);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic,
// checked against a cycle-level reference model and a model memory.
module tb_dmem_arbiter;

  localparam int SM = 4;
  localparam int BM = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we, dma_lock;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .STARVE_MAX(SM), .BURST_MAX(BM)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_re_i(cpu_re), .cpu_we_i(cpu_we),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_stall_o(cpu_stall), .cpu_rdata_o(cpu_rdata),
    .cpu_rvalid_o(cpu_rvalid),
    .dma_req_i(dma_req), .dma_we_i(dma_we),
    .dma_lock_i(dma_lock),
    .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_gnt_o(dma_gnt), .dma_rdata_o(dma_rdata),
    .dma_rvalid_o(dma_rvalid),
    .mem_re_o(mem_re), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] seed(input int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 32) return 32'h0000_1111;
    if (i == 36) return 32'h0000_2222;
    return 32'hA500_0000 | (i * 32'h101);
  endfunction

  logic        preload;
  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  int          lost;
  bit          locked;
  int          burst_n;
  int          pend;
  logic [31:0] pend_data;

  int n_vec = 0;
  int n_err = 0;

  logic        o_stall, o_gnt, o_crv, o_drv, o_re, o_we;
  logic [31:0] o_crd, o_drd;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cre, input logic cwe,
                       input logic [31:0] ca, input logic [31:0] cw,
                       input logic dr, input logic dwe, input logic dl,
                       input logic [31:0] da, input logic [31:0] dw);
    cpu_re = cre; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cw;
    dma_req = dr; dma_we = dwe; dma_lock = dl;
    dma_addr = da; dma_wdata = dw;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check one cycle against the model, then advance the model and clock.
  task automatic tick();
    bit cact, dg, cg;
    logic e_re, e_we;
    logic [31:0] e_a, e_w;
    #1;
    o_stall = cpu_stall; o_gnt = dma_gnt;
    o_crv = cpu_rvalid; o_drv = dma_rvalid;
    o_crd = cpu_rdata; o_drd = dma_rdata;
    o_re = mem_re; o_we = mem_we;
    if (rst) begin
      chk1("rst_stall", cpu_stall, 1'b0);
      chk1("rst_gnt", dma_gnt, 1'b0);
      chk1("rst_mem_re", mem_re, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_crv", cpu_rvalid, 1'b0);
      chk1("rst_drv", dma_rvalid, 1'b0);
      chk32("rst_crd", cpu_rdata, 32'h0);
      chk32("rst_drd", dma_rdata, 32'h0);
      chk32("rst_addr", mem_addr, 32'h0);
      chk32("rst_wdata", mem_wdata, 32'h0);
      pend = 0; lost = 0; locked = 0; burst_n = 0;
    end else begin
      cact = cpu_re | cpu_we;
      dg = dma_req && (locked || !cact || lost == SM);
      cg = cact && !dg;
      e_re = 1'b0; e_we = 1'b0; e_a = cpu_addr; e_w = cpu_wdata;
      if (cg) begin
        e_we = cpu_we;
        e_re = cpu_re && !cpu_we;
      end else if (dg) begin
        e_we = dma_we;
        e_re = !dma_we;
        e_a = dma_addr;
        e_w = dma_wdata;
      end
      chk1("cpu_stall", cpu_stall, cact && !cg);
      chk1("dma_gnt", dma_gnt, dg);
      chk1("mem_re", mem_re, e_re);
      chk1("mem_we", mem_we, e_we);
      chk32("mem_addr", mem_addr, e_a);
      chk32("mem_wdata", mem_wdata, e_w);
      chk1("cpu_rvalid", cpu_rvalid, pend == 1);
      chk1("dma_rvalid", dma_rvalid, pend == 2);
      if (pend != 0) begin
        chk32("cpu_rdata", cpu_rdata, pend_data);
        chk32("dma_rdata", dma_rdata, pend_data);
      end
      pend = 0;
      if (e_re) begin
        pend = cg ? 1 : 2;
        pend_data = ref_mem[e_a[7:0]];
      end
      if (e_we) ref_mem[e_a[7:0]] = e_w;
      if (dg || !dma_req) lost = 0;
      else if (cg) lost = (lost < SM) ? lost + 1 : SM;
      if (!locked) begin
        if (dg && dma_lock) begin
          locked = 1; burst_n = 1;
        end
      end else if (!dma_req) begin
        locked = 0;
      end else begin
        burst_n++;
        if (!dma_lock || burst_n == BM) locked = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [5:0] spat, gpat;
  int gcnt, scnt;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    lost = 0; locked = 0; burst_n = 0; pend = 0; pend_data = '0;
    rst = 1'b1; preload = 1'b1;
    drive(1, 0, 32'h10, 32'h5, 1, 1, 1, 32'h20, 32'h7);
    @(negedge clk);
    tick();
    preload = 1'b0;
    tick();
    rst = 1'b0;
    idle();
    tick();

    // CPU-only read
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    tick();
    chk1("c0_re", o_re, 1'b1);
    chk1("c0_stall", o_stall, 1'b0);
    idle();
    tick();
    chk1("c1_crv", o_crv, 1'b1);
    chk32("c1_crd", o_crd, 32'hDEADBEEF);
    chk1("c1_drv", o_drv, 1'b0);

    // Starvation
    idle(); tick();
    drive(1, 0, 32'h40, 0, 1, 0, 0, 32'h44, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      spat[i] = o_stall;
      gpat[i] = o_gnt;
    end
    chk32("starve_stall", {26'd0, spat}, 32'b010000);
    chk32("starve_gnt", {26'd0, gpat}, 32'b010000);

    // Full locked burst
    idle(); tick();
    gcnt = 0; scnt = 0;
    drive(0, 0, 0, 0, 1, 0, 1, 32'h50, 0);
    tick();
    gcnt += int'(o_gnt);
    drive(1, 0, 32'h60, 0, 1, 1, 1, 32'h51, 32'h99);
    for (int i = 1; i < 17; i++) begin
      dma_addr = 32'h50 + i;
      tick();
      gcnt += int'(o_gnt);
      scnt += int'(o_stall);
    end
    chk32("burst_gnts", gcnt, 32'd16);
    chk32("burst_stalls", scnt, 32'd15);
    chk1("burst_end_stall", o_stall, 1'b0);

    // Early unlock on third grant
    idle(); tick();
    drive(0, 0, 0, 0, 1, 0, 1, 32'h70, 0);
    tick(); gpat[0] = o_gnt; spat[0] = o_stall;
    drive(1, 0, 32'h74, 0, 1, 0, 1, 32'h71, 0);
    tick(); gpat[1] = o_gnt; spat[1] = o_stall;
    dma_lock = 0;
    tick(); gpat[2] = o_gnt; spat[2] = o_stall;
    dma_lock = 1;
    tick(); gpat[3] = o_gnt; spat[3] = o_stall;
    chk32("unlock_gnt", {28'd0, gpat[3:0]}, 32'b0111);
    chk32("unlock_stall", {28'd0, spat[3:0]}, 32'b0110);

    // Mixed read return
    idle(); tick();
    drive(0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
    tick();
    drive(1, 0, 32'h24, 0, 0, 0, 0, 0, 0);
    tick();
    chk1("mix1_drv", o_drv, 1'b1);
    chk1("mix1_crv", o_crv, 1'b0);
    chk32("mix1_drd", o_drd, 32'h1111);
    idle();
    tick();
    chk1("mix2_crv", o_crv, 1'b1);
    chk1("mix2_drv", o_drv, 1'b0);
    chk32("mix2_crd", o_crd, 32'h2222);

    // Reset mid-read
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    drive(1, 0, 32'h10, 0, 1, 0, 1, 32'h20, 0);
    tick();
    chk1("rstr1_crv", o_crv, 1'b0);
    rst = 1'b0;
    idle();
    tick();
    chk1("rstr2_crv", o_crv, 1'b0);
    chk1("rstr2_drv", o_drv, 1'b0);

    // Write wins over read when both set
    drive(1, 1, 32'h30, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    tick();
    chk1("wp_we", o_we, 1'b1);
    chk1("wp_re", o_re, 1'b0);
    drive(1, 0, 32'h30, 0, 0, 0, 0, 0, 0);
    tick();
    chk1("wp_crv", o_crv, 1'b0);
    idle();
    tick();
    chk32("wp_rd", o_crd, 32'hCAFEF00D);

    // Random traffic; a stalled CPU holds its request.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!o_stall || rst) begin
        cpu_re = ($urandom_range(0, 9) < 6);
        cpu_we = ($urandom_range(0, 9) < 3);
        cpu_addr = 32'($urandom_range(0, 255));
        cpu_wdata = $urandom;
      end
      dma_req = ($urandom_range(0, 3) != 0);
      dma_we = ($urandom_range(0, 2) == 0);
      dma_lock = ($urandom_range(0, 9) < 7);
      dma_addr = 32'($urandom_range(0, 255));
      dma_wdata = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
